sample_stats: RTL and testbench

//  Streaming statistics consumer directly downstream of normalRandom.

---
 rtl/sample_stats_if.sv | 30 +++
 rtl/sample_stats.sv | 162 ++++++++++++++++
 tb/tb_sample_stats.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_stats_if.sv
// Sample stream in, block statistics out, for the sample_stats checker.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready on the sample side, out_valid/out_ready on the result side.
interface sample_stats_if #(
    parameter int DATA_W = 32,
    parameter int LOG2_N = 10
);
    logic                  start;
    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  in_ready;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     mean;
    logic [2*DATA_W-1:0]   variance;
    logic [LOG2_N:0]       count;

    // Producer side: drives samples and start, consumes results.
    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, busy, out_valid, mean, variance, count
    );

    // Statistics block side.
    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, busy, out_valid, mean, variance, count
    );
endinterface

// File: rtl/sample_stats.sv
// Block mean/variance over 2**LOG2_N signed samples from the random generator.
// Latency: result valid 4 cycles after the last accepted sample of a block.
// Backpressure: in_ready only while accumulating; result held until out_ready.
module sample_stats #(
    parameter int DATA_W = 32,
    parameter int LOG2_N = 10
) (
    input  logic           clk,
    input  logic           rst,
    sample_stats_if.slave  bus
);

    localparam int SUM_W   = DATA_W + LOG2_N;
    localparam int SQ_W    = 2 * DATA_W;
    localparam int SUMSQ_W = 2 * DATA_W + LOG2_N;
    localparam int CNT_W   = LOG2_N + 1;

    // Count value at which the accept being taken is the last of the block.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_N) - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DRAIN,
        MEAN,
        VAR,
        DONE
    } state_t;

    state_t                     state;
    logic signed [SUM_W-1:0]    sum;
    logic [SUMSQ_W-1:0]         sumsq;
    logic [SQ_W-1:0]            sq_reg;
    logic                       sq_vld;
    logic [CNT_W-1:0]           cnt;
    logic signed [DATA_W-1:0]   mean_r;
    logic [SQ_W-1:0]            var_r;
    logic                       in_ready_r;
    logic                       busy_r;
    logic                       out_valid_r;

    logic                       accept;
    logic signed [SQ_W-1:0]     sq_next;
    logic signed [SUM_W-1:0]    data_ext;
    logic signed [SQ_W-1:0]     mean_sq;
    logic [SQ_W-1:0]            sumsq_div;
    logic [SQ_W:0]              var_diff;
    logic [SQ_W-1:0]            var_next;

    assign accept    = bus.in_valid & in_ready_r;

    // A square is never negative, so the signed product is reused as unsigned.
    assign sq_next   = $signed(bus.in_data) * $signed(bus.in_data);
    assign data_ext  = SUM_W'($signed(bus.in_data));

    // Mean squared of the freshly registered mean; |mean| <= 2**(DATA_W-1) keeps it in SQ_W.
    assign mean_sq   = mean_r * mean_r;

    // Mean of squares: dropping the low LOG2_N bits is the divide by N.
    assign sumsq_div = sumsq[SUMSQ_W-1:LOG2_N];

    // One extra bit carries the borrow; a borrow means rounding made E[x^2] < mean^2.
    assign var_diff  = {1'b0, sumsq_div} - {1'b0, mean_sq};
    assign var_next  = var_diff[SQ_W] ? '0 : var_diff[SQ_W-1:0];

    // Square pipeline stage: capture in_data^2 on each accept, flag it for the sumsq add.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sq_reg <= '0;
            sq_vld <= 1'b0;
        end else begin
            sq_vld <= accept;
            if (accept) begin
                sq_reg <= sq_next;
            end
        end
    end

    // Block sequencer: accumulate, drain the square stage, derive mean then variance, hold result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sum         <= '0;
            sumsq       <= '0;
            cnt         <= '0;
            mean_r      <= '0;
            var_r       <= '0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            // Squares land one cycle behind their sample, including the block's last one in DRAIN.
            if (sq_vld) begin
                sumsq <= sumsq + SUMSQ_W'(sq_reg);
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= ACCUM;
                        sum        <= '0;
                        sumsq      <= '0;
                        cnt        <= '0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end

                ACCUM: begin
                    if (accept) begin
                        sum <= sum + data_ext;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            state      <= DRAIN;
                            in_ready_r <= 1'b0;
                        end
                    end
                end

                DRAIN: begin
                    state <= MEAN;
                end

                MEAN: begin
                    // Top DATA_W bits of sum are exactly sum >>> LOG2_N (floor division).
                    mean_r <= sum[SUM_W-1:LOG2_N];
                    state  <= VAR;
                end

                VAR: begin
                    var_r       <= var_next;
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end

                DONE: begin
                    // A start seen here is dropped: a new block needs a start while IDLE.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b0;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.mean      = mean_r;
    assign bus.variance  = var_r;
    assign bus.count     = cnt;

endmodule

// File: tb/tb_sample_stats.sv
// Randomised and directed stimulus for sample_stats against a block-level reference model.
// Latency: checks result arrival 4 cycles after the last accepted sample.
// Backpressure: exercises input gaps, over-supply of samples and held-off result consumption.
module tb_sample_stats;

    localparam int DATA_W = 32;
    localparam int LOG2_N = 2;
    localparam int N      = 1 << LOG2_N;

    logic clk;
    logic rst;

    sample_stats_if #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) ss ();

    sample_stats #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ss.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit pat[7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases seen from outside: idle, taking samples, computing, result offered.
    typedef enum int {P_IDLE, P_TAKE, P_CALC, P_DONE} phase_t;

    phase_t       m_phase;
    int           m_cnt;
    int           m_calc;
    logic [31:0]  m_mean;
    logic [63:0]  m_var;
    int           blk[$];

    function automatic logic [31:0] ref_mean(input int q[$]);
        longint s;
        longint qq;
        s = 0;
        foreach (q[i]) s += longint'(q[i]);
        qq = s / N;
        if ((s % N) != 0 && s < 0) qq = qq - 1;
        return qq[31:0];
    endfunction

    function automatic logic [63:0] ref_var(input int q[$]);
        logic signed [127:0] ssq;
        logic signed [127:0] d;
        longint m;
        ssq = 0;
        foreach (q[i]) ssq += 128'(longint'(q[i]) * longint'(q[i]));
        m = longint'($signed(ref_mean(q)));
        d = ssq / N - 128'(m * m);
        if (d < 0) return 64'd0;
        return d[63:0];
    endfunction

    // Mean appears 3 cycles after the last accept, variance and out_valid 4 cycles after.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= P_IDLE;
            m_cnt   <= 0;
            m_calc  <= 0;
            m_mean  <= '0;
            m_var   <= '0;
            blk.delete();
        end else begin
            case (m_phase)
                P_IDLE: if (ss.start) begin
                    m_phase <= P_TAKE;
                    m_cnt   <= 0;
                    blk.delete();
                end
                P_TAKE: if (ss.in_valid) begin
                    blk.push_back(int'(ss.in_data));
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == N - 1) begin
                        m_phase <= P_CALC;
                        m_calc  <= 1;
                    end
                end
                P_CALC: begin
                    m_calc <= m_calc + 1;
                    if (m_calc == 2) m_mean <= ref_mean(blk);
                    if (m_calc == 3) begin
                        m_var   <= ref_var(blk);
                        m_phase <= P_DONE;
                    end
                end
                P_DONE: if (ss.out_ready) m_phase <= P_IDLE;
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    // Every-cycle comparison of all DUT outputs with the model.
    always @(negedge clk) begin
        chk("in_ready",  64'(ss.in_ready),  64'(m_phase == P_TAKE));
        chk("busy",      64'(ss.busy),      64'(m_phase != P_IDLE));
        chk("out_valid", 64'(ss.out_valid), 64'(m_phase == P_DONE));
        chk("count",     64'(ss.count),     64'(m_cnt));
        chk("mean",      64'(ss.mean),      64'(m_mean));
        chk("variance",  ss.variance,       m_var);
    end

    // ---------------- stimulus ----------------
    // mode 0: back-to-back, 1: fixed gap pattern, 2: random gaps.
    task automatic run_block(input int s0, input int s1, input int s2, input int s3,
                             input int mode, input bit extra, input int hold,
                             input bit lit, input logic [31:0] exp_mean, input logic [63:0] exp_var);
        int  smp[4];
        int  idx;
        int  k;
        int  acc_cyc;
        bit  v;
        bit  seen;
        smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
        acc_cyc = 0;
        @(negedge clk);
        ss.start = 1'b1;
        @(negedge clk);
        ss.start = 1'b0;
        idx = 0;
        k   = 0;
        while (idx < N && k < 100) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (k < 7) ? pat[k] : 1'b1;
                default: v = ($urandom % 3) != 0;
            endcase
            ss.in_valid = v;
            ss.in_data  = smp[idx];
            if (v && m_phase == P_TAKE) begin
                idx++;
                acc_cyc = cyc;
            end
            @(negedge clk);
            k++;
        end
        ss.in_valid = extra;
        ss.in_data  = extra ? 32'd99 : 32'd0;
        seen = 1'b0;
        for (int j = 0; j < 20; j++) begin
            if (ss.out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            chk("out_valid_timeout", 64'd0, 64'd1);
        end else begin
            chk("latency", 64'(cyc - acc_cyc), 64'd4);
            if (lit) begin
                chk("lit_mean",  64'(ss.mean),  64'(exp_mean));
                chk("lit_var",   ss.variance,   exp_var);
                chk("model_mean", 64'(m_mean),  64'(exp_mean));
                chk("model_var", m_var,         exp_var);
                chk("lit_count", 64'(ss.count), 64'(N));
            end
            if (extra) chk("fifth_unconsumed", 64'(ss.in_ready), 64'd0);
            for (int h = 0; h < hold; h++) begin
                ss.start = h[0];
                @(negedge clk);
            end
            if (lit && hold > 0) begin
                chk("held_mean", 64'(ss.mean), 64'(exp_mean));
                chk("held_var",  ss.variance,  exp_var);
                chk("held_valid", 64'(ss.out_valid), 64'd1);
            end
            ss.out_ready = 1'b1;
            ss.start     = 1'b1;
            @(negedge clk);
            ss.out_ready = 1'b0;
            ss.start     = 1'b0;
            ss.in_valid  = 1'b0;
            @(negedge clk);
            chk("idle_after_start_in_done", 64'(ss.busy), 64'd0);
        end
    endtask

    function automatic int rand_sample();
        int sel;
        sel = int'($urandom % 3);
        if (sel == 0) return int'($urandom);
        if (sel == 1) return int'($urandom_range(0, 200)) - 100;
        return ($urandom % 2) ? int'(32'h7FFF_FFFF) : int'(32'h8000_0000);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
        rst          = 1'b0;
        ss.start     = 1'b0;
        ss.in_valid  = 1'b0;
        ss.in_data   = '0;
        ss.out_ready = 1'b0;

        // Reset with inputs toggling.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ss.start    = i[0];
            ss.in_valid = ~i[0];
            ss.in_data  = $urandom;
        end
        @(negedge clk);
        chk("rst_out_valid", 64'(ss.out_valid), 64'd0);
        chk("rst_in_ready",  64'(ss.in_ready),  64'd0);
        chk("rst_busy",      64'(ss.busy),      64'd0);
        chk("rst_mean",      64'(ss.mean),      64'd0);
        chk("rst_variance",  ss.variance,       64'd0);
        chk("rst_count",     64'(ss.count),     64'd0);
        ss.start    = 1'b0;
        ss.in_valid = 1'b0;
        #2 rst = 1'b1;

        // Basic block: mean 2, variance 30/4=7 minus 4.
        run_block(1, 2, 3, 4, 0, 1'b0, 0, 1'b1, 32'd2, 64'd3);
        // Negative values with clamp: floor(-5/4) = -2, 7/4=1 minus 4 clamps.
        run_block(-1, -1, -1, -2, 0, 1'b0, 1, 1'b1, 32'hFFFF_FFFE, 64'd0);
        // Full-scale negative and a constant block.
        run_block(int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000),
                  0, 1'b0, 0, 1'b1, 32'h8000_0000, 64'd0);
        run_block(7, 7, 7, 7, 0, 1'b0, 0, 1'b1, 32'd7, 64'd0);
        // Gapped input, over-supplied 5th sample, result held 10 cycles with starts in DONE.
        // sum 100 -> 25; squares 3000/4 = 750 minus 625.
        run_block(10, 20, 30, 40, 1, 1'b1, 10, 1'b1, 32'd25, 64'd125);

        // Abort a block after two samples with reset.
        @(negedge clk);
        ss.start = 1'b1;
        @(negedge clk);
        ss.start    = 1'b0;
        ss.in_valid = 1'b1;
        ss.in_data  = 32'd100;
        @(negedge clk);
        ss.in_data  = -32'sd50;
        @(negedge clk);
        ss.in_valid = 1'b0;
        chk("pre_abort_count", 64'(ss.count), 64'd2);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("abort_count", 64'(ss.count), 64'd0);
        chk("abort_busy",  64'(ss.busy),  64'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        run_block(5, 5, 5, 5, 0, 1'b0, 0, 1'b1, 32'd5, 64'd0);

        // Random blocks with random gaps, holds and stray inputs between blocks.
        for (int b = 0; b < 25; b++) begin
            int a0, a1, a2, a3;
            a0 = rand_sample();
            a1 = rand_sample();
            a2 = rand_sample();
            a3 = rand_sample();
            run_block(a0, a1, a2, a3, 2, 1'($urandom % 2), int'($urandom_range(0, 4)),
                      1'b0, 32'd0, 64'd0);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                ss.in_valid = 1'($urandom % 2);
                ss.in_data  = $urandom;
                @(negedge clk);
            end
            ss.in_valid = 1'b0;
        end

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
